// File: rtl/cam_tx_pkg.sv
// Shared types and constants for the camera stream transmitter.
package cam_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_e;

    typedef enum logic [1:0] {
        MODE_BARS,
        MODE_SOLID,
        MODE_RAMP,
        MODE_CHECK
    } mode_e;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][15:0] BAR_COLORS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: maps pixel coordinates and the latched
// mode/colour to one RGB565 pixel.
module cam_pattern_gen
    import cam_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640
) (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  mode_e       mode_i,
    input  logic [15:0] color_i,
    output logic [15:0] pix_o
);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [15:0] bar_idx;
    logic        unused_bits;

    assign bar_idx     = x_i / 16'(BAR_W);
    assign unused_bits = ^{y_i[15:6], y_i[4:0], bar_idx[15:3]};

    always_comb begin
        pix_o = '0;
        unique case (mode_i)
            MODE_BARS:  pix_o = BAR_COLORS[bar_idx[2:0]];
            MODE_SOLID: pix_o = color_i;
            MODE_RAMP:  pix_o = {x_i[7:3], x_i[7:2], x_i[7:3]};
            MODE_CHECK: pix_o = (x_i[5] ^ y_i[5]) ? 16'hFFFF : 16'h0000;
            default:    pix_o = '0;
        endcase
    end

endmodule

// File: rtl/cam_stream_tx.sv
// OV7670-style camera stream transmitter: VSYNC/HREF/DATA frame timing with a
// selectable RGB565 test pattern sent high byte first.
module cam_stream_tx
    import cam_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned VS_LINES = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    output logic        cam_href,
    output logic        cam_vsync,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy
);
    localparam int unsigned L  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned CW = $clog2(L);
    localparam int unsigned LW = $clog2(VS_LINES + V_BACK + V_ACTIVE + V_FRONT);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d, last_line;
    mode_e         mode_q, mode_d;
    logic [15:0]   color_q, color_d;
    logic          latch;
    logic [15:0]   x_d, y_d, pix;
    logic          href_d, done_d;
    logic [7:0]    data_d;

    always_comb begin
        unique case (state_q)
            ST_VSYNC:  last_line = LW'(VS_LINES - 1);
            ST_VBACK:  last_line = LW'(V_BACK - 1);
            ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
            default:   last_line = LW'(V_FRONT - 1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        latch   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable) begin
                state_d = ST_VSYNC;
                col_d   = '0;
                line_d  = '0;
                latch   = 1'b1;
            end
        end else if (col_q == CW'(L - 1)) begin
            col_d = '0;
            if (line_q == last_line) begin
                line_d = '0;
                unique case (state_q)
                    ST_VSYNC:  state_d = ST_VBACK;
                    ST_VBACK:  state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFRONT;
                    default: begin
                        state_d = enable ? ST_VSYNC : ST_IDLE;
                        latch   = enable;
                    end
                endcase
            end else begin
                line_d = line_q + 1'b1;
            end
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    assign mode_d  = latch ? mode_e'(mode) : mode_q;
    assign color_d = latch ? solid_color : color_q;

    // Outputs are derived from the next position so every output is a flop
    // that lines up with the state/counter it describes.
    assign x_d    = 16'(col_d >> 1);
    assign y_d    = 16'(line_d);
    assign href_d = (state_d == ST_ACTIVE) && (col_d < CW'(2 * H_ACTIVE));
    assign data_d = href_d ? (col_d[0] ? pix[7:0] : pix[15:8]) : '0;
    assign done_d = (state_d == ST_VFRONT) && (col_d == CW'(L - 1))
                 && (line_d == LW'(V_FRONT - 1));

    cam_pattern_gen #(
        .H_ACTIVE(H_ACTIVE)
    ) u_pattern (
        .x_i    (x_d),
        .y_i    (y_d),
        .mode_i (mode_d),
        .color_i(color_d),
        .pix_o  (pix)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            line_q     <= '0;
            mode_q     <= MODE_BARS;
            color_q    <= '0;
            cam_href   <= 1'b0;
            cam_vsync  <= 1'b0;
            cam_data   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_q     <= line_d;
            mode_q     <= mode_d;
            color_q    <= color_d;
            cam_href   <= href_d;
            cam_vsync  <= (state_d == ST_VSYNC);
            cam_data   <= data_d;
            frame_done <= done_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: doc/cam_stream_tx.md
# cam_stream_tx

Synthesizable OV7670-style camera stream transmitter. It produces VSYNC/HREF/8-bit DATA with RGB565 pixels sent as two bytes, high byte first, which is exactly the byte order the camera-to-VGA receiver path assembles. It sits in place of the physical camera on the `cam_*` bus so the display path can be brought up and regressed without a sensor. It generates the frame timing plus a selectable test pattern.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per active line; must be a multiple of 8 and at least 8.
- `H_BLANK`, 144: `clk` cycles with HREF low at the end of each line; at least 1.
- `V_ACTIVE`, 480: active lines per frame; at least 1.
- `VS_LINES`, 3: line-times with VSYNC high; at least 1.
- `V_BACK`, 17: line-times between VSYNC falling and the first active line; at least 1.
- `V_FRONT`, 10: line-times after the last active line; at least 1.

Ports:
- `clk`  in  1: sole clock; each cycle carries one data byte.
- `reset_n`  in  1: synchronous, active-low reset.
- `enable`  in  1: request continuous frame generation.
- `mode`  in  2: pattern select. 0 = colour bars, 1 = solid, 2 = grey ramp, 3 = checkerboard.
- `solid_color`  in  16: RGB565 value used in mode 1.
- `cam_href`  out  1: row-valid, high for the 2·H_ACTIVE byte cycles of each active line.
- `cam_vsync`  out  1: frame sync, active high.
- `cam_data`  out  8: pixel byte; 0 whenever `cam_href` is low.
- `frame_done`  out  1: one-cycle pulse on the last cycle of each frame.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Line length: L = 2·H_ACTIVE + H_BLANK cycles. Column counter `col` runs 0..L−1 and wraps; line counter `line` counts line-times within the current state.
- State machine states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE → VSYNC: when `enable` = 1. This sets col = 0 and latches `mode` and `solid_color`.
  - VSYNC → VBACK: after VS_LINES lines.
  - VBACK → ACTIVE: after V_BACK lines.
  - ACTIVE → VFRONT: after V_ACTIVE lines.
  - VFRONT → VSYNC: after V_FRONT lines, if `enable` = 1; this also re-latches `mode` and `solid_color`.
  - VFRONT → IDLE: after V_FRONT lines, if `enable` = 0.
- `enable` is sampled only in IDLE and at the end of VFRONT. Deasserting it mid-frame always completes the current frame.
- `mode` and `solid_color` changes mid-frame have no effect until the next frame starts.
- `cam_vsync` = 1 for every cycle of VSYNC.
- In ACTIVE with col < 2·H_ACTIVE:
  - `cam_href` = 1.
  - Pixel x = col>>1; y = active line index.
  - Byte `col[0]` = 0 carries pix[15:8]; `col[0]` = 1 carries pix[7:0].
- Patterns:
  - Bars: bar index = x / (H_ACTIVE/8), giving FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Solid: latched `solid_color`.
  - Ramp: pix = {x[7:3], x[7:2], x[7:3]}.
  - Checker: (x[5] ^ y[5]) ? FFFF : 0000.
- `frame_done` pulses on the final cycle of VFRONT, including when the next state is IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0, and state = IDLE.
- Latency: `enable` high in IDLE at cycle n gives `cam_vsync` = 1 and `busy` = 1 at cycle n+1.
- VSYNC lasts exactly VS_LINES·L cycles. The first HREF rise is (VS_LINES+V_BACK)·L cycles after VSYNC rise.
- Frame length: (VS_LINES+V_BACK+V_ACTIVE+V_FRONT)·L cycles. With continuous `enable` there is no gap between frames; VSYNC re-rises the cycle after `frame_done`.
- `cam_href` and `cam_data` change together. Each HREF pulse has an even byte count and always starts on a high byte.
- `reset_n` low mid-frame: on the next edge all outputs are 0 and state is IDLE. No partial line is completed.

## Structure
- Package `cam_tx_pkg` holds:
  - the state enum;
  - the mode enum;
  - the eight RGB565 bar-colour constants.
- Sub-module `cam_pattern_gen` maps (x, y, latched mode, latched colour) to a 16-bit pixel combinationally. The top module registers its output together with the byte select.

## Test plan
Use small parameters: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS_LINES=1, V_BACK=1, V_FRONT=1. This gives L=20 and a 140-cycle frame.
- **Reset:** hold `reset_n`=0 with `enable`=1 → all outputs stay 0. Release, then one cycle later `cam_vsync`=1, which lasts exactly 20 cycles.
- **Colour bars:** mode 0 → each HREF pulse is 16 cycles carrying FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00. There are 4 pulses per frame, and `cam_data`=0 between pulses.
- **Solid, mid-frame change:** mode 1 with `solid_color`=16'hABCD → bytes alternate AB,CD. Changing to 16'h1234 mid-frame leaves the current frame at AB,CD; the next frame carries 12,34.
- **Enable drop:** deassert `enable` during ACTIVE → the frame completes with 4 HREF pulses, then `frame_done` pulses at cycle 139 of the frame. `busy`=0 from the next cycle, with no further VSYNC.
- **Reset mid-line:** assert `reset_n`=0 at byte 5 of an HREF pulse → outputs are 0 on the next cycle. After release with `enable`=1, a full fresh frame starts with VSYNC.
- **Receiver loopback:** feed the receiver with checkerboard mode and H_ACTIVE=64 → assembled pixels alternate FFFF/0000 every 32 pixels, and the phase flips every 32 lines.
